game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game controller for the tetris chip. It sequences the `clear_redraw` datapath by driving its 3-bit `state` command and 2-bit `curr_piece` select. It also times gravity steps, scans the returned 32-bit board for full rows, and keeps score and game-over status. It sits between the player/start logic and `clear_redraw`, in the same clock domain.

## Interface
- `DROP_TICKS`, 8: clock cycles between gravity steps; legal range 2..255.
- `LFSR_SEED`, 4'b1001: reset value of the piece LFSR; must be nonzero.

- `clka`  in  1  single system clock, rising-edge.
- `restart_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level, sampled on the clock; begins a game from IDLE and acknowledges game over from OVER.
- `board_in`  in  32  board from `clear_redraw`; row r = bits [4r+3:4r], row 0 = bottom, bit 4r = column 0.
- `dp_error`  in  1  datapath reports that the active piece cannot move or spawn.
- `state`  out  3  command to `clear_redraw`, equal to the FSM encoding.
- `curr_piece`  out  2  piece select for `clear_redraw`.
- `step`  out  1  one-cycle gravity pulse to the datapath.
- `clear_row`  out  3  row index currently scanned or cleared.
- `score`  out  8  count of cleared rows, saturating.
- `game_over`  out  1  high while in OVER.
- `busy`  out  1  high in every state except IDLE and OVER.

## Operation
- FSM encoding: IDLE=0, SPAWN=1, FALL=2, LOCK=3, SCAN=4, CLEAR=5, OVER=6. Code 7 is unreachable and recovers to IDLE.
- IDLE: when `start`=1, go to SPAWN. Score clears to 0 on this transition.
- SPAWN, 1 cycle: latch `curr_piece` <= `lfsr[1:0]`, clear the drop counter, then go to FALL.
- FALL:
  - First FALL cycle after SPAWN with `dp_error`=1: go to OVER (spawn collision).
  - Any later FALL cycle with `dp_error`=1: go to LOCK.
  - Otherwise the drop counter counts 0..DROP_TICKS-1. At terminal count, `step`=1 for that cycle and the counter wraps to 0.
- LOCK, 1 cycle: `clear_row` <= 0, then go to SCAN.
- SCAN, 1 cycle per row:
  - If `board_in[4*clear_row+3 : 4*clear_row]` == 4'hF, go to CLEAR.
  - Else if `clear_row`==7, go to SPAWN.
  - Else increment `clear_row` and stay in SCAN.
- CLEAR, 1 cycle: the datapath collapses the rows above `clear_row`. Score increments by 1, saturating at 255. Return to SCAN with `clear_row` unchanged, so the collapsed row is rechecked.
- OVER: `game_over`=1; when `start`=1, go to IDLE.
- Piece LFSR: 4-bit Fibonacci, taps x^4+x^3+1, shifts every cycle in every state. Period 15; it never reaches 0.
- `start` is ignored in SPAWN through CLEAR. `dp_error` is ignored outside FALL.

## Timing
- Reset values: `state`=0 (IDLE), `curr_piece`=0, `step`=0, `clear_row`=0, `score`=0, `game_over`=0, `busy`=0. LFSR = `LFSR_SEED`; drop counter = 0.
- All outputs are registered. `state` changes one clock after the qualifying input is sampled.
- `start` to first `step`: 1 (IDLE→SPAWN) + 1 (SPAWN→FALL) + DROP_TICKS cycles.
- `step` period in FALL is exactly DROP_TICKS cycles, with no gaps across counter wrap.
- Simultaneous terminal count and `dp_error` in FALL: `dp_error` wins; no `step` pulse; go to LOCK.
- Lock to respawn with no full rows: LOCK + 8 SCAN cycles = 9 cycles, then SPAWN.
- Each full row adds 2 cycles (CLEAR plus rescan). The loop is bounded because every clear removes 4 set bits from the board.
- Reset asserted mid-operation: all registers return to reset values immediately, asynchronously. Operation resumes on the first clock edge after `restart_n` deasserts.

## Test plan
- Reset, then `start`=1 for 1 cycle with DROP_TICKS=8: `state` follows 0→1→2; `step` pulses on cycles 10, 18, 26 after `start`; `busy`=1.
- In FALL after the first cycle, raise `dp_error` for 1 cycle with `board_in`=0: LOCK, then 8 SCAN cycles (`clear_row` 0..7), then SPAWN; `score` stays 0; `curr_piece` equals the LFSR bits at SPAWN.
- Lock with `board_in`=32'h0000000F; drive `board_in`=0 once CLEAR is seen: row 0 SCAN→CLEAR→SCAN with `clear_row`=0, `score`=1, then continue to SPAWN.
- Raise `dp_error` on the first FALL cycle after SPAWN: `state`=6, `game_over`=1, `busy`=0; `start` then returns to IDLE; a second `start` clears `score`.
- Preload `score`=254 through three single-row clears: `score` reads 255 and holds at 255.
- Assert `restart_n`=0 while in SCAN and then in CLEAR: all outputs return to reset values without a clock edge; LFSR reloads 4'b1001.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: top-level tetris game controller.
// Drives the clear_redraw command/piece select, times gravity steps, scans the
// returned board for full rows, and keeps score and game-over status.
module game_sequencer #(
  parameter int unsigned DROP_TICKS = 8,        // cycles between gravity steps, 2..255
  parameter logic [3:0]  LFSR_SEED  = 4'b1001   // nonzero piece LFSR seed
) (
  input  logic        clka,
  input  logic        restart_n,
  input  logic        start,
  input  logic [31:0] board_in,
  input  logic        dp_error,
  output logic [2:0]  state,
  output logic [1:0]  curr_piece,
  output logic        step,
  output logic [2:0]  clear_row,
  output logic [7:0]  score,
  output logic        game_over,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_FALL  = 3'd2,
    S_LOCK  = 3'd3,
    S_SCAN  = 3'd4,
    S_CLEAR = 3'd5,
    S_OVER  = 3'd6,
    S_BAD   = 3'd7
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(DROP_TICKS - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        first_q, first_d;      // high during the first FALL cycle after SPAWN
  logic [1:0]  piece_q, piece_d;
  logic [2:0]  row_q, row_d;
  logic [7:0]  score_q, score_d;
  logic        step_q, step_d;
  logic        over_q, over_d;
  logic        busy_q, busy_d;
  logic [3:0]  lfsr_q;
  logic        row_full;

  // Piece LFSR: x^4+x^3+1 Fibonacci, free-running in every state.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples the pre-edge value of every other flop.
      lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      piece_q <= '0;
      row_q   <= '0;
      score_q <= '0;
      step_q  <= 1'b0;
      over_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      piece_q <= piece_d;
      row_q   <= row_d;
      score_q <= score_d;
      step_q  <= step_d;
      over_q  <= over_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; status outputs are decoded from the next state so they
  // stay registered and aligned with state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    piece_d  = piece_q;
    row_d    = row_q;
    score_d  = score_q;
    step_d   = 1'b0;
    row_full = (board_in[{row_q, 2'b00} +: 4] == 4'hF);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SPAWN;
          score_d = '0;
        end
      end
      S_SPAWN: begin
        piece_d = lfsr_q[1:0];
        cnt_d   = '0;
        first_d = 1'b1;
        state_d = S_FALL;
      end
      S_FALL: begin
        first_d = 1'b0;
        if (dp_error) begin
          // A collision on the very first FALL cycle means the spawn failed.
          state_d = first_q ? S_OVER : S_LOCK;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          step_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LOCK: begin
        row_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (row_full) begin
          state_d = S_CLEAR;
        end else if (row_q == 3'd7) begin
          state_d = S_SPAWN;
        end else begin
          row_d = row_q + 3'd1;
        end
      end
      S_CLEAR: begin
        // Row index is kept so the collapsed row is rescanned.
        if (score_q != 8'hFF) score_d = score_q + 8'd1;
        state_d = S_SCAN;
      end
      S_OVER: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    over_d = (state_d == S_OVER);
    busy_d = (state_d != S_IDLE) && (state_d != S_OVER);
  end

  assign state      = state_q;
  assign curr_piece = piece_q;
  assign step       = step_q;
  assign clear_row  = row_q;
  assign score      = score_q;
  assign game_over  = over_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with DROP_TICKS=8.
module tb_game_sequencer;

  logic        clka = 1'b0;
  logic        restart_n;
  logic        start;
  logic [31:0] board_in;
  logic        dp_error;
  logic [2:0]  state;
  logic [1:0]  curr_piece;
  logic        step;
  logic [2:0]  clear_row;
  logic [7:0]  score;
  logic        game_over;
  logic        busy;

  int          checks   = 0;
  int          failures = 0;
  logic [3:0]  m_lfsr;
  logic [1:0]  exp_piece;

  game_sequencer #(.DROP_TICKS(8), .LFSR_SEED(4'b1001)) dut (
    .clka       (clka),
    .restart_n  (restart_n),
    .start      (start),
    .board_in   (board_in),
    .dp_error   (dp_error),
    .state      (state),
    .curr_piece (curr_piece),
    .step       (step),
    .clear_row  (clear_row),
    .score      (score),
    .game_over  (game_over),
    .busy       (busy)
  );

  always #5 clka = ~clka;

  // Reference model of the piece LFSR (x^4+x^3+1, seed 1001).
  always @(posedge clka or negedge restart_n) begin
    if (!restart_n) m_lfsr <= 4'b1001;
    else            m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_piece"}, 32'(curr_piece), 32'd0);
    check({tag, "_step"}, 32'(step), 32'd0);
    check({tag, "_row"}, 32'(clear_row), 32'd0);
    check({tag, "_score"}, 32'(score), 32'd0);
    check({tag, "_over"}, 32'(game_over), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n = 0;
    while (state !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(state), 32'(target));
  endtask

  initial begin
    restart_n = 1'b0;
    start     = 1'b0;
    board_in  = '0;
    dp_error  = 1'b0;
    #12;
    check_reset("reset0");

    // Release reset and start right away; edge 1 samples start.
    restart_n = 1'b1;
    start     = 1'b1;
    tick();                                   // edge 1
    check("spawn_state", 32'(state), 32'd1);
    check("spawn_busy", 32'(busy), 32'd1);
    start = 1'b0;
    tick();                                   // edge 2
    check("fall_state", 32'(state), 32'd2);
    check("first_piece", 32'(curr_piece), 32'd3);   // LFSR 1001 -> 0011 at SPAWN

    // Gravity pulses on edges 10, 18, 26 after start.
    for (int k = 3; k <= 26; k++) begin
      tick();
      check($sformatf("step_e%0d", k), 32'(step), 32'(k == 10 || k == 18 || k == 26));
    end
    check("fall_busy", 32'(busy), 32'd1);

    // Lock with empty board: LOCK, 8 SCAN rows, SPAWN.
    dp_error = 1'b1;
    tick();                                   // edge 27
    check("lock_state", 32'(state), 32'd3);
    check("lock_step", 32'(step), 32'd0);
    dp_error = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("scan_state_%0d", i), 32'(state), 32'd4);
      check($sformatf("scan_row_%0d", i), 32'(clear_row), 32'(i));
    end
    tick();
    check("respawn_state", 32'(state), 32'd1);
    check("respawn_score", 32'(score), 32'd0);
    exp_piece = m_lfsr[1:0];
    tick();
    check("respawn_fall", 32'(state), 32'd2);
    check("respawn_piece", 32'(curr_piece), 32'(exp_piece));

    // Single full row at the bottom.
    tick();
    dp_error = 1'b1;
    board_in = 32'h0000_000F;
    tick();
    check("clr_lock", 32'(state), 32'd3);
    dp_error = 1'b0;
    tick();
    check("clr_scan", 32'(state), 32'd4);
    check("clr_scan_row", 32'(clear_row), 32'd0);
    tick();
    check("clr_clear", 32'(state), 32'd5);
    check("clr_clear_row", 32'(clear_row), 32'd0);
    check("clr_score_before", 32'(score), 32'd0);
    board_in = '0;
    tick();
    check("clr_rescan", 32'(state), 32'd4);
    check("clr_rescan_row", 32'(clear_row), 32'd0);
    check("clr_score_after", 32'(score), 32'd1);
    wait_state(3'd1, 12, "clr_to_spawn");
    check("clr_score_kept", 32'(score), 32'd1);

    // Spawn collision -> OVER, acknowledge, new game clears score.
    tick();
    check("go_fall", 32'(state), 32'd2);
    dp_error = 1'b1;
    tick();
    check("go_state", 32'(state), 32'd6);
    check("go_flag", 32'(game_over), 32'd1);
    check("go_busy", 32'(busy), 32'd0);
    dp_error = 1'b0;
    start    = 1'b1;
    tick();
    check("ack_state", 32'(state), 32'd0);
    check("ack_flag", 32'(game_over), 32'd0);
    check("ack_score", 32'(score), 32'd1);
    start = 1'b0;
    tick();
    check("idle_hold", 32'(state), 32'd0);
    start = 1'b1;
    tick();
    check("restart_spawn", 32'(state), 32'd1);
    check("restart_score", 32'(score), 32'd0);
    start = 1'b0;

    // Hold row 0 full so SCAN/CLEAR loops up to and past saturation.
    tick();
    tick();
    dp_error = 1'b1;
    board_in = 32'h0000_000F;
    tick();
    check("sat_lock", 32'(state), 32'd3);
    dp_error = 1'b0;
    for (int n = 0; n < 700 && score !== 8'd254; n++) tick();
    check("sat_254", 32'(score), 32'd254);
    check("sat_254_state", 32'(state), 32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_clear_%0d", i), 32'(state), 32'd5);
      tick();
      check($sformatf("sat_score_%0d", i), 32'(score), 32'd255);
    end

    // Asynchronous reset while in SCAN.
    #2 restart_n = 1'b0;
    #1 check_reset("rst_scan");
    #1 restart_n = 1'b1;
    board_in = '0;
    start    = 1'b1;
    tick();
    check("post_rst_spawn", 32'(state), 32'd1);
    start = 1'b0;
    tick();
    check("post_rst_piece", 32'(curr_piece), 32'd3);   // LFSR reloaded to 1001

    // Asynchronous reset while in CLEAR.
    tick();
    dp_error = 1'b1;
    board_in = 32'h0000_000F;
    tick();
    dp_error = 1'b0;
    tick();
    tick();
    check("rst_clear_pre", 32'(state), 32'd5);
    #2 restart_n = 1'b0;
    #1 check_reset("rst_clear");
    #1 restart_n = 1'b1;
    board_in = '0;
    tick();
    check("rst_clear_idle", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
